// File: rtl/mem_stage_outstanding.sv
// Split-transaction memory stage: issues requests, tracks up to DEPTH in-order accesses
// in a completion queue, aligns/extends load data and cancels responses on flush.
module mem_stage_outstanding #(
    parameter int          DEPTH    = 2,
    parameter int          SIDE_W   = 48,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_pc,
    input  logic [31:0]                  in_addr,
    input  logic [7:0]                   in_mem_op,
    input  logic [31:0]                  in_wdata,
    input  logic [SIDE_W-1:0]            in_side,
    input  logic                         in_exc,
    input  logic                         in_ertn,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_pc,
    output logic [31:0]                  out_result,
    output logic [SIDE_W-1:0]            out_side,
    output logic                         out_exc,
    output logic                         out_ertn,
    input  logic                         flush,
    output logic                         this_flush,
    output logic                         data_req,
    output logic                         data_wr,
    output logic [1:0]                   data_size,
    output logic [3:0]                   data_wstrb,
    output logic [31:0]                  data_addr,
    output logic [31:0]                  data_wdata,
    input  logic                         data_addr_ok,
    input  logic                         data_data_ok,
    input  logic [31:0]                  data_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]       r_pc    [DEPTH];
    logic [31:0]       r_addr  [DEPTH];
    logic [7:0]        r_op    [DEPTH];
    logic [SIDE_W-1:0] r_side  [DEPTH];
    logic              r_exc   [DEPTH];
    logic              r_ertn  [DEPTH];
    logic              r_done  [DEPTH];
    logic [31:0]       r_rdata [DEPTH];

    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count, r_outstanding, r_cancel;
    logic          r_block;

    logic          w_need_req, w_full, w_accept, w_issue, w_pop, w_rsp_valid;
    logic          w_mark_found;
    logic [PW-1:0] w_mark_idx;
    logic [7:0]    w_hop;
    logic [31:0]   w_haddr, w_hdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign w_need_req  = in_valid & (|in_mem_op) & ~in_exc & ~in_ertn & ~r_block & ~flush;
    assign w_full      = (r_count == CW'(DEPTH));
    assign data_req    = w_need_req & ~w_full & (r_outstanding < CW'(DEPTH));
    assign in_ready    = rst & ~flush & ~w_full & (~w_need_req | (data_req & data_addr_ok));
    assign w_accept    = in_valid & in_ready;
    assign w_issue     = w_accept & w_need_req;
    assign w_rsp_valid = data_data_ok & (r_outstanding != '0);
    assign w_pop       = out_valid & out_ready;
    assign this_flush  = r_block | (in_valid & (in_exc | in_ertn));
    assign outstanding = r_outstanding;

    assign data_wr    = in_mem_op[5] | in_mem_op[6] | in_mem_op[7];
    assign data_addr  = {in_addr[31:2], 2'b00};
    assign data_size  = (in_mem_op[2] | in_mem_op[7]) ? 2'd2 :
                        (in_mem_op[1] | in_mem_op[4] | in_mem_op[6]) ? 2'd1 : 2'd0;
    assign data_wstrb = in_mem_op[7] ? 4'b1111 :
                        in_mem_op[6] ? (4'b0011 << in_addr[1:0]) :
                        in_mem_op[5] ? (4'b0001 << in_addr[1:0]) : 4'b0000;
    assign data_wdata = in_mem_op[5] ? {4{in_wdata[7:0]}} :
                        in_mem_op[6] ? {2{in_wdata[15:0]}} : in_wdata;

    // Responses come back in order, so the oldest not-done entry owns the next data_ok.
    always_comb begin
        w_mark_found = 1'b0;
        w_mark_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_mark_found && (i < int'(r_count)) && !r_done[wrapIdx(r_head, i)]) begin
                w_mark_found = 1'b1;
                w_mark_idx   = wrapIdx(r_head, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_cancel      <= '0;
            r_block       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= RESET_PC;
                r_addr[i]  <= '0;
                r_op[i]    <= '0;
                r_side[i]  <= '0;
                r_exc[i]   <= 1'b0;
                r_ertn[i]  <= 1'b0;
                r_done[i]  <= 1'b0;
                r_rdata[i] <= '0;
            end
        end else if (flush) begin
            // Everything still in flight becomes a response to be discarded.
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_block       <= 1'b0;
            r_outstanding <= r_outstanding - CW'(w_rsp_valid);
            r_cancel      <= r_outstanding - CW'(w_rsp_valid);
        end else begin
            if (w_accept) begin
                r_pc[r_tail]   <= in_pc;
                r_addr[r_tail] <= in_addr;
                r_op[r_tail]   <= in_mem_op;
                r_side[r_tail] <= in_side;
                r_exc[r_tail]  <= in_exc;
                r_ertn[r_tail] <= in_ertn;
                r_done[r_tail] <= ~w_issue;
                r_tail         <= nextPtr(r_tail);
                if (in_exc | in_ertn) r_block <= 1'b1;
            end
            if (w_rsp_valid) begin
                if (r_cancel != '0) begin
                    r_cancel <= r_cancel - CW'(1);
                end else if (w_mark_found) begin
                    r_done[w_mark_idx]  <= 1'b1;
                    r_rdata[w_mark_idx] <= data_rdata;
                end
            end
            if (w_pop) r_head <= nextPtr(r_head);
            r_count       <= r_count + CW'(w_accept) - CW'(w_pop);
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp_valid);
        end
    end

    assign w_hop   = r_op[r_head];
    assign w_haddr = r_addr[r_head];
    assign w_hdata = r_rdata[r_head];

    always_comb begin
        case (w_haddr[1:0])
            2'd0:    w_byte = w_hdata[7:0];
            2'd1:    w_byte = w_hdata[15:8];
            2'd2:    w_byte = w_hdata[23:16];
            default: w_byte = w_hdata[31:24];
        endcase
        w_half = w_haddr[1] ? w_hdata[31:16] : w_hdata[15:0];
        if (w_hop[0])      out_result = {{24{w_byte[7]}}, w_byte};
        else if (w_hop[3]) out_result = {24'd0, w_byte};
        else if (w_hop[1]) out_result = {{16{w_half[15]}}, w_half};
        else if (w_hop[4]) out_result = {16'd0, w_half};
        else if (w_hop[2]) out_result = w_hdata;
        else               out_result = w_haddr;
    end

    assign out_valid = (r_count != '0) & r_done[r_head];
    assign out_pc    = r_pc[r_head];
    assign out_side  = r_side[r_head];
    assign out_exc   = r_exc[r_head];
    assign out_ertn  = r_ertn[r_head];

endmodule
